// File: rtl/rc_pkt_check.sv
// rc_pkt_check: receive-side packet checker behind bitUnstuffer.
// Strips and checks the PID, runs serial CRC16 on DATA, checks length.
module rc_pkt_check #(
  parameter int PAYLOAD_BITS = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_in,
  input  logic                    start_decode,
  input  logic                    end_decode,
  input  logic                    bitUnstuff_wait,
  input  logic                    abort,
  input  logic                    receive_data,
  input  logic                    receive_hshake,
  output logic [3:0]              pid_out,
  output logic [PAYLOAD_BITS-1:0] data_out,
  output logic                    pkt_done,
  output logic                    pkt_ok,
  output logic                    pid_error,
  output logic                    crc_error,
  output logic                    len_error
);

  localparam int BB = PAYLOAD_BITS + 16;
  localparam int CW = $clog2(BB + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(BB);
  localparam logic [CW-1:0] CNT_SAT  = CW'(BB + 1);
  localparam logic [CW-1:0] CNT_PID  = CW'(7);
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'h8005;
  localparam logic [15:0] CRC_GOOD = 16'h800D;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PID,
    S_BODY,
    S_WAIT_END,
    S_REPORT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]           r_cnt;
  logic [15:0]             r_crc;
  logic [7:0]              r_pid_sr;
  logic [BB-1:0]           r_body_sr;
  logic                    r_data_mode;
  logic                    r_len_bad;
  logic [3:0]              r_pid_out;
  logic [PAYLOAD_BITS-1:0] r_data_out;
  logic                    r_pkt_ok;
  logic                    r_pid_err;
  logic                    r_crc_err;
  logic                    r_len_err;

  logic w_bit;
  logic w_valid;
  logic w_start;
  logic w_rep_ld;
  logic w_fb;
  logic w_pid_err;
  logic w_len_err;
  logic w_crc_err;

  assign w_bit   = !bitUnstuff_wait && !end_decode;
  assign w_valid = w_bit &&
                   (r_state == S_PID || r_state == S_BODY);
  assign w_start = (r_state == S_IDLE) && start_decode;
  assign w_rep_ld = (w_next == S_REPORT);
  assign w_fb    = s_in ^ r_crc[15];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // abort outranks every other event once a packet is open
  always_comb begin
    w_next = r_state;
    if (r_state != S_IDLE && abort) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start_decode) w_next = S_PID;
        end
        S_PID: begin
          if (end_decode)
            w_next = S_REPORT;
          else if (w_valid && r_cnt == CNT_PID)
            w_next = r_data_mode ? S_BODY : S_WAIT_END;
        end
        S_BODY: begin
          if (end_decode) w_next = S_REPORT;
        end
        S_WAIT_END: begin
          if (end_decode) w_next = S_REPORT;
        end
        S_REPORT: w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    pkt_done = (r_state == S_REPORT);
  end

  assign w_pid_err = (r_pid_sr[7:4] != ~r_pid_sr[3:0]);

  always_comb begin
    w_len_err = 1'b0;
    unique case (1'b1)
      r_state == S_PID:      w_len_err = 1'b1;
      r_state == S_WAIT_END: w_len_err = r_len_bad;
      r_state == S_BODY:     w_len_err = (r_cnt != CNT_FULL);
      default:               w_len_err = 1'b0;
    endcase
  end

  assign w_crc_err = (r_state == S_BODY) && !w_len_err &&
                     (r_crc != CRC_GOOD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_crc       <= CRC_INIT;
      r_pid_sr    <= '0;
      r_body_sr   <= '0;
      r_data_mode <= 1'b0;
      r_len_bad   <= 1'b0;
      r_pid_out   <= '0;
      r_data_out  <= '0;
      r_pkt_ok    <= 1'b0;
      r_pid_err   <= 1'b0;
      r_crc_err   <= 1'b0;
      r_len_err   <= 1'b0;
    end else if (w_start) begin
      r_cnt       <= '0;
      r_crc       <= CRC_INIT;
      r_pid_sr    <= '0;
      r_body_sr   <= '0;
      // neither mode strobe falls back to data mode
      r_data_mode <= receive_data || !receive_hshake;
      r_len_bad   <= 1'b0;
      r_pid_out   <= '0;
      r_data_out  <= '0;
      r_pkt_ok    <= 1'b0;
      r_pid_err   <= 1'b0;
      r_crc_err   <= 1'b0;
      r_len_err   <= 1'b0;
    end else begin
      if (w_valid && r_state == S_PID) begin
        r_pid_sr <= {s_in, r_pid_sr[7:1]};
        r_cnt    <= (r_cnt == CNT_PID) ? '0 : r_cnt + 1'b1;
      end
      if (w_valid && r_state == S_BODY) begin
        r_body_sr <= {s_in, r_body_sr[BB-1:1]};
        r_crc     <= {r_crc[14:0], 1'b0} ^
                     (w_fb ? CRC_POLY : 16'h0000);
        if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == S_WAIT_END && w_bit)
        r_len_bad <= 1'b1;
      if (w_rep_ld) begin
        r_pid_out <= r_pid_sr[3:0];
        r_pid_err <= w_pid_err;
        r_len_err <= w_len_err;
        r_crc_err <= w_crc_err;
        r_pkt_ok  <= !(w_pid_err || w_len_err || w_crc_err);
        if (r_state == S_BODY)
          r_data_out <= r_body_sr[PAYLOAD_BITS-1:0];
      end
    end
  end

  assign pid_out   = r_pid_out;
  assign data_out  = r_data_out;
  assign pkt_ok    = r_pkt_ok;
  assign pid_error = r_pid_err;
  assign crc_error = r_crc_err;
  assign len_error = r_len_err;

endmodule

// File: tb/tb_rc_pkt_check.sv
// tb_rc_pkt_check: scenario tasks driving serial packets into
// rc_pkt_check, with expected reports queued per packet.
module tb_rc_pkt_check;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_in;
  logic        start_decode;
  logic        end_decode;
  logic        bitUnstuff_wait;
  logic        abort;
  logic        receive_data;
  logic        receive_hshake;
  logic [3:0]  pid_out;
  logic [63:0] data_out;
  logic        pkt_done;
  logic        pkt_ok;
  logic        pid_error;
  logic        crc_error;
  logic        len_error;

  typedef struct {
    logic [3:0]  pid;
    logic [63:0] data;
    logic        ok;
    logic        pe;
    logic        ce;
    logic        le;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;

  localparam logic [63:0] PL0 = 64'h7FFE_0000_0000_0000;
  localparam logic [63:0] PL1 = 64'hDEAD_BEEF_0123_4567;

  always #5 clk = ~clk;

  always @(posedge clk) if (pkt_done === 1'b1) done_cnt++;

  rc_pkt_check #(.PAYLOAD_BITS(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .s_in           (s_in),
    .start_decode   (start_decode),
    .end_decode     (end_decode),
    .bitUnstuff_wait(bitUnstuff_wait),
    .abort          (abort),
    .receive_data   (receive_data),
    .receive_hshake (receive_hshake),
    .pid_out        (pid_out),
    .data_out       (data_out),
    .pkt_done       (pkt_done),
    .pkt_ok         (pkt_ok),
    .pid_error      (pid_error),
    .crc_error      (crc_error),
    .len_error      (len_error)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // payload LSB-first, then inverted CRC16 sent high bit first
  function automatic logic [127:0] build_body(input logic [63:0] pl);
    logic [15:0]  crc;
    logic         fb;
    logic [127:0] b;
    crc = 16'hFFFF;
    b = '0;
    for (int i = 0; i < 64; i++) begin
      b[i] = pl[i];
      fb = pl[i] ^ crc[15];
      crc = {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    for (int k = 0; k < 16; k++) b[64+k] = ~crc[15-k];
    return b;
  endfunction

  task automatic push_exp(input logic [3:0] pid, input logic [63:0] d,
                          input logic ok, input logic pe,
                          input logic ce, input logic le);
    exp_t e;
    e.pid = pid;
    e.data = d;
    e.ok = ok;
    e.pe = pe;
    e.ce = ce;
    e.le = le;
    sb.push_back(e);
  endtask

  task automatic send_pkt(input logic [7:0] pid, input logic md,
                          input logic mh, input logic [127:0] body,
                          input int nbody, input int wait_at,
                          input int stop_at, input int start_at);
    start_decode = 1'b1;
    receive_data = md;
    receive_hshake = mh;
    tick();
    start_decode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_in = pid[i];
      tick();
    end
    for (int i = 0; i < nbody; i++) begin
      if (i == stop_at) return;
      if (i == wait_at) begin
        repeat (2) begin
          bitUnstuff_wait = 1'b1;
          s_in = 1'b1;
          tick();
        end
        bitUnstuff_wait = 1'b0;
      end
      s_in = body[i];
      start_decode = (i == start_at);
      tick();
      start_decode = 1'b0;
    end
    if (stop_at == nbody) return;
    end_decode = 1'b1;
    tick();
    end_decode = 1'b0;
  endtask

  task automatic check_report(input string nm);
    exp_t e;
    n_cmp++;
    if (pkt_done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s pkt_done: got %b want 1", nm, pkt_done);
    end
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s scoreboard: got empty want entry", nm);
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if (pid_out !== e.pid) begin
      n_bad++;
      $display("FAIL %s pid_out: got %h want %h", nm, pid_out, e.pid);
    end
    n_cmp++;
    if (data_out !== e.data) begin
      n_bad++;
      $display("FAIL %s data_out: got %h want %h", nm, data_out, e.data);
    end
    n_cmp++;
    if ({pkt_ok, pid_error, crc_error, len_error} !==
        {e.ok, e.pe, e.ce, e.le}) begin
      n_bad++;
      $display("FAIL %s ok/pe/ce/le: got %b%b%b%b want %b%b%b%b", nm,
               pkt_ok, pid_error, crc_error, len_error,
               e.ok, e.pe, e.ce, e.le);
    end
    tick();
    n_cmp++;
    if (pkt_done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s pulse width: got %b want 0", nm, pkt_done);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if ({pkt_done, pkt_ok, pid_error, crc_error, len_error} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset flags: got %b want 00000",
               {pkt_done, pkt_ok, pid_error, crc_error, len_error});
    end
    n_cmp++;
    if (pid_out !== 4'h0) begin
      n_bad++;
      $display("FAIL reset pid_out: got %h want 0", pid_out);
    end
    n_cmp++;
    if (data_out !== 64'h0) begin
      n_bad++;
      $display("FAIL reset data_out: got %h want 0", data_out);
    end
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_data_good();
    push_exp(4'h3, PL0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_pkt(8'hC3, 1'b1, 1'b0, build_body(PL0), 80, 20, -1, -1);
    check_report("data0");
    push_exp(4'h3, PL1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_pkt(8'hC3, 1'b1, 1'b1, build_body(PL1), 80, -1, -1, -1);
    check_report("both_modes");
  endtask

  task automatic test_crc_flip();
    logic [127:0] b;
    b = build_body(PL0);
    b[17] = ~b[17];
    push_exp(4'h3, PL0 ^ (64'h1 << 17), 1'b0, 1'b0, 1'b1, 1'b0);
    send_pkt(8'hC3, 1'b1, 1'b0, b, 80, -1, -1, -1);
    check_report("crc_flip");
  endtask

  task automatic test_hshake();
    push_exp(4'h2, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_pkt(8'hD2, 1'b0, 1'b1, '0, 0, -1, -1, -1);
    check_report("ack");
    push_exp(4'h3, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_pkt(8'hD3, 1'b0, 1'b1, '0, 0, -1, -1, -1);
    check_report("ack_bad_pid");
    push_exp(4'h2, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_pkt(8'hD2, 1'b0, 1'b1, 128'h5, 3, -1, -1, -1);
    check_report("ack_long");
  endtask

  task automatic test_trunc();
    logic [127:0] b;
    logic [63:0]  ed;
    b = build_body(PL1);
    ed = '0;
    for (int j = 10; j < 64; j++) ed[j] = b[j-10];
    push_exp(4'h3, ed, 1'b0, 1'b0, 1'b0, 1'b1);
    send_pkt(8'hC3, 1'b1, 1'b0, b, 70, -1, -1, -1);
    check_report("trunc70");
  endtask

  task automatic test_abort();
    int dc;
    dc = done_cnt;
    send_pkt(8'hC3, 1'b1, 1'b0, build_body(PL0), 80, -1, 30, -1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (done_cnt !== dc) begin
      n_bad++;
      $display("FAIL abort pkt_done: got %0d want %0d", done_cnt, dc);
    end
    n_cmp++;
    if ({pkt_ok, pid_out} !== 5'h0) begin
      n_bad++;
      $display("FAIL abort status: got %b want 0", {pkt_ok, pid_out});
    end
    push_exp(4'h3, PL0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_pkt(8'hC3, 1'b1, 1'b0, build_body(PL0), 80, -1, -1, -1);
    check_report("after_abort");
  endtask

  task automatic test_rst_mid();
    int dc;
    dc = done_cnt;
    send_pkt(8'hC3, 1'b1, 1'b0, build_body(PL1), 80, -1, 40, -1);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({pkt_done, pkt_ok, pid_out, data_out} !== 70'h0) begin
      n_bad++;
      $display("FAIL rst_mid outputs: got %h want 0",
               {pkt_done, pkt_ok, pid_out, data_out});
    end
    tick();
    rst = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (done_cnt !== dc) begin
      n_bad++;
      $display("FAIL rst_mid pkt_done: got %0d want %0d", done_cnt, dc);
    end
    push_exp(4'h3, PL1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_pkt(8'hC3, 1'b1, 1'b0, build_body(PL1), 80, -1, -1, -1);
    check_report("after_rst");
  endtask

  task automatic test_end_abort();
    int dc;
    dc = done_cnt;
    send_pkt(8'hC3, 1'b1, 1'b0, build_body(PL0), 80, -1, 80, -1);
    end_decode = 1'b1;
    abort = 1'b1;
    tick();
    end_decode = 1'b0;
    abort = 1'b0;
    n_cmp++;
    if (pkt_done !== 1'b0) begin
      n_bad++;
      $display("FAIL end_abort pkt_done: got %b want 0", pkt_done);
    end
    repeat (3) tick();
    n_cmp++;
    if (done_cnt !== dc) begin
      n_bad++;
      $display("FAIL end_abort count: got %0d want %0d", done_cnt, dc);
    end
  endtask

  task automatic test_start_in_body();
    push_exp(4'h3, PL1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_pkt(8'hC3, 1'b1, 1'b0, build_body(PL1), 80, -1, -1, 25);
    check_report("start_in_body");
  endtask

  initial begin
    rst = 1'b1;
    s_in = 1'b0;
    start_decode = 1'b0;
    end_decode = 1'b0;
    bitUnstuff_wait = 1'b0;
    abort = 1'b0;
    receive_data = 1'b0;
    receive_hshake = 1'b0;
    test_reset();
    test_data_good();
    test_crc_flip();
    test_hshake();
    test_trunc();
    test_abort();
    test_rst_mid();
    test_end_abort();
    test_start_in_body();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rc_pkt_check.md
Name: rc_pkt_check

Overview:
- Receive-side packet checker that sits directly downstream of bitUnstuffer in the host receive chain (rc_dpdm -> decode_nrzi -> bitUnstuffer -> rc_pkt_check).
- Consumes the serial, already-unstuffed bit stream framed by start_decode/end_decode and strips the PID.
- Validates the PID against its complement nibble, runs a serial CRC16 over DATA packets, checks length, and presents the payload and status to the protocol FSM.

Parameters:
- PAYLOAD_BITS, 64, data payload width excluding PID and CRC16.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- s_in  input  1  unstuffed serial bit from bitUnstuffer, USB LSB-first order
- start_decode  input  1  pulse; first PID bit is on s_in the following cycle
- end_decode  input  1  pulse; no valid bit this cycle, packet complete
- bitUnstuff_wait  input  1  high = stuffed bit being dropped, s_in invalid this cycle
- abort  input  1  receive abort from rc_dpdm, kills the packet in progress
- receive_data  input  1  expect DATA packet (PID + payload + CRC16)
- receive_hshake  input  1  expect handshake (PID only)
- pid_out  output  4  received PID nibble
- data_out  output  PAYLOAD_BITS  payload; first received bit at bit 0
- pkt_done  output  1  one-cycle pulse, status outputs valid
- pkt_ok  output  1  PID, CRC and length all good
- pid_error  output  1  upper nibble != ~lower nibble
- crc_error  output  1  CRC16 residual mismatch
- len_error  output  1  wrong bit count for the expected packet type

Behaviour:
- Reset: state IDLE; pid_out=0; data_out=0; all status outputs 0; crc register 16'hFFFF; bit counter 0.
- Valid bit: any cycle in PID or BODY with bitUnstuff_wait=0 and end_decode=0. Counter increments only on valid bits.
- States and transitions:
  - IDLE: start_decode -> PID; clear counter, crc=16'hFFFF, shift register=0. Mode is latched from receive_data/receive_hshake; if both are high, data takes priority.
  - PID: shift 8 valid bits into pid_sr, LSB first. After the 8th bit: handshake mode -> WAIT_END; data mode -> BODY. end_decode before 8 bits -> REPORT with len_error=1.
  - BODY: each valid bit is shifted in at the MSB of an (PAYLOAD_BITS+16)-bit register (right shift) and fed to the CRC. On end_decode -> REPORT.
  - WAIT_END (handshake mode): any valid bit sets len_error; end_decode -> REPORT.
  - REPORT: single cycle.
    - pkt_done=1.
    - pid_out=pid_sr[3:0]; pid_error=(pid_sr[7:4] != ~pid_sr[3:0]).
    - data_out=body_sr[PAYLOAD_BITS-1:0] (data mode only; unchanged otherwise).
    - len_error=(body count != PAYLOAD_BITS+16) in data mode.
    - crc_error=(crc != 16'h800D) in data mode, suppressed (0) if len_error.
    - pkt_ok = no error flag set.
    - Next state IDLE.
- CRC16: fb = s_in ^ crc[15]; crc <= {crc[14:0],1'b0} ^ (fb ? 16'h8005 : 16'h0). Computed over payload and received CRC bits, not the PID. Good residual is 16'h800D.
- Status hold: pid_out, data_out and the error flags hold until the next REPORT. They are cleared to 0 on entry to PID.
- Abort: in any non-IDLE state, abort -> IDLE the next cycle with no pkt_done. Error flags stay 0 because they were cleared on entry to PID.
- Simultaneous events:
  - abort with end_decode: abort wins.
  - start_decode while not IDLE: ignored.
  - end_decode while IDLE: ignored.
- Back-to-back: start_decode in the same cycle as REPORT is not accepted; upstream guarantees a gap of at least 1 cycle.
- Async rst mid-packet: everything returns to reset values immediately; no pkt_done is emitted.
- Latency: pkt_done is asserted in the cycle after end_decode.

Test Plan:
- DATA0: PID 8'hC3 LSB-first, payload 64'h7FFE_0000_0000_0000, correct CRC16, with 2 bitUnstuff_wait cycles inserted mid-payload -> pkt_done one cycle after end_decode; pid_out=4'h3, data_out=64'h7FFE_0000_0000_0000, pkt_ok=1, all errors 0.
- Same packet with payload bit 17 flipped -> crc_error=1, pkt_ok=0, pid_error=0, len_error=0.
- Handshake ACK 8'hD2 in receive_hshake mode -> pid_out=4'h2, pkt_ok=1. Repeat with 8'hD3 -> pid_error=1.
- DATA packet truncated to 70 body bits -> len_error=1, crc_error=0, pkt_ok=0.
- Two cases -> no pkt_done, state IDLE, next good packet passes with pkt_ok=1:
  - abort asserted after 30 payload bits.
  - rst pulsed mid-payload.
- end_decode and abort asserted in the same cycle -> no pkt_done. start_decode while in BODY -> ignored, packet completes normally.
